// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, hazard/redirect
// inputs and the IF/ID write port. The master side belongs to the fetch unit.
interface fetch_unit_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] ifinstr;
    logic [31:0] ifJALjump_addr;
    logic        ifW;
    logic        ifRST;
    logic        halted;

    modport master (
        output imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST, halted,
        input  ihit, imemload, stall, redirect, redirect_addr
    );

    modport slave (
        input  imemREN, imemaddr, ifinstr, ifJALjump_addr, ifW, ifRST, halted,
        output ihit, imemload, stall, redirect, redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-word requests to the
// instruction memory, forwards returned words with their PC+4 into IF/ID,
// buffers one word across a stall, follows redirects and parks on the halt word.
module fetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pendAddr_q, pendAddr_d;
    logic [31:0] bufInstr_q, bufInstr_d;
    logic [31:0] bufNpc_q, bufNpc_d;
    logic        bufHalt_q, bufHalt_d;

    logic [31:0] npc;
    logic        isHaltWord;

    assign npc        = pc_q + 32'd4;
    assign isHaltWord = (bus.imemload == HALT_WORD);

    // State register: everything returns to a clean fetch from PC_INIT on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH;
            pc_q       <= PC_INIT;
            pend_q     <= 1'b0;
            pendAddr_q <= 32'd0;
            bufInstr_q <= 32'd0;
            bufNpc_q   <= 32'd0;
            bufHalt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pendAddr_q <= pendAddr_d;
            bufInstr_q <= bufInstr_d;
            bufNpc_q   <= bufNpc_d;
            bufHalt_q  <= bufHalt_d;
        end
    end

    // Next state and outputs; priority is reset, redirect, delivery, then stall.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        pend_d             = pend_q;
        pendAddr_d         = pendAddr_q;
        bufInstr_d         = bufInstr_q;
        bufNpc_d           = bufNpc_q;
        bufHalt_d          = bufHalt_q;

        bus.imemREN        = 1'b0;
        bus.imemaddr       = pc_q;
        bus.ifW            = 1'b0;
        bus.ifRST          = 1'b0;
        bus.halted         = 1'b0;
        bus.ifinstr        = 32'd0;
        bus.ifJALjump_addr = 32'd0;

        if (RST) begin
            bus.imemaddr = 32'd0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    bus.imemREN = 1'b1;
                    if (bus.redirect) begin
                        bus.ifW   = 1'b1;
                        bus.ifRST = 1'b1;
                        if (bus.ihit) begin
                            pc_d   = bus.redirect_addr;
                            pend_d = 1'b0;
                        end else begin
                            // The in-flight address must stay stable, so park the target.
                            pend_d     = 1'b1;
                            pendAddr_d = bus.redirect_addr;
                        end
                    end else if (bus.ihit) begin
                        if (pend_q) begin
                            pc_d   = pendAddr_q;
                            pend_d = 1'b0;
                        end else if (!bus.stall) begin
                            bus.ifW            = 1'b1;
                            bus.ifinstr        = bus.imemload;
                            bus.ifJALjump_addr = npc;
                            pc_d               = npc;
                            state_d            = isHaltWord ? HALT : FETCH;
                        end else begin
                            bufInstr_d = bus.imemload;
                            bufNpc_d   = npc;
                            bufHalt_d  = isHaltWord;
                            pc_d       = npc;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    bus.ifinstr        = bufInstr_q;
                    bus.ifJALjump_addr = bufNpc_q;
                    if (bus.redirect) begin
                        bus.ifW   = 1'b1;
                        bus.ifRST = 1'b1;
                        pc_d      = bus.redirect_addr;
                        pend_d    = 1'b0;
                        state_d   = FETCH;
                    end else if (!bus.stall) begin
                        bus.ifW = 1'b1;
                        state_d = bufHalt_q ? HALT : FETCH;
                    end
                end
                HALT: begin
                    bus.halted = 1'b1;
                    if (bus.redirect) begin
                        bus.ifW   = 1'b1;
                        bus.ifRST = 1'b1;
                        pc_d      = bus.redirect_addr;
                        pend_d    = 1'b0;
                        state_d   = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall hold, redirects with and
// without a request in flight, halt handling, PC wrap and mid-request reset.
module tb_fetch_unit;

    logic CLK;
    logic RST;
    int   testCount;
    int   failCount;

    fetch_unit_if bus ();

    fetch_unit #(
        .PC_INIT  (32'h0000_0000),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic applyStimulus(input logic hit, input logic [31:0] load, input logic stl,
                                 input logic redir, input logic [31:0] raddr);
        bus.ihit          = hit;
        bus.imemload      = load;
        bus.stall         = stl;
        bus.redirect      = redir;
        bus.redirect_addr = raddr;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        applyStimulus(1'b1, 32'h12, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        #1;
        testCount++; if (bus.imemREN !== 1'b0) begin failCount++; $display("[TB] FAIL reset_imemREN got %h expected 0", bus.imemREN); end
        testCount++; if (bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ifW got %h expected 0", bus.ifW); end
        testCount++; if (bus.ifRST !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ifRST got %h expected 0", bus.ifRST); end
        testCount++; if (bus.halted !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halted got %h expected 0", bus.halted); end
        testCount++; if (bus.ifinstr !== 32'h0) begin failCount++; $display("[TB] FAIL reset_ifinstr got %h expected 0", bus.ifinstr); end
        testCount++; if (bus.ifJALjump_addr !== 32'h0) begin failCount++; $display("[TB] FAIL reset_ifJAL got %h expected 0", bus.ifJALjump_addr); end
        RST = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemREN !== 1'b1) begin failCount++; $display("[TB] FAIL first_imemREN got %h expected 1", bus.imemREN); end
        testCount++; if (bus.imemaddr !== 32'h0) begin failCount++; $display("[TB] FAIL first_imemaddr got %h expected 0", bus.imemaddr); end
        nextCycle();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(i + 1), 1'b0, 1'b0, 32'h0);
            #1;
            testCount++; if (bus.imemaddr !== 32'(4 * i)) begin failCount++; $display("[TB] FAIL stream_addr%0d got %h expected %h", i, bus.imemaddr, 32'(4 * i)); end
            testCount++; if (bus.ifW !== 1'b1 || bus.ifRST !== 1'b0) begin failCount++; $display("[TB] FAIL stream_write%0d got ifW=%h ifRST=%h expected 1/0", i, bus.ifW, bus.ifRST); end
            testCount++; if (bus.ifinstr !== 32'(i + 1)) begin failCount++; $display("[TB] FAIL stream_instr%0d got %h expected %h", i, bus.ifinstr, 32'(i + 1)); end
            testCount++; if (bus.ifJALjump_addr !== 32'(4 * i + 4)) begin failCount++; $display("[TB] FAIL stream_npc%0d got %h expected %h", i, bus.ifJALjump_addr, 32'(4 * i + 4)); end
            nextCycle();
        end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            #1;
            testCount++; if (bus.imemaddr !== 32'hC || bus.imemREN !== 1'b1) begin failCount++; $display("[TB] FAIL latency_addr%0d got %h/%h expected 0000000c/1", i, bus.imemaddr, bus.imemREN); end
            testCount++; if (bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL latency_ifW%0d got %h expected 0", i, bus.ifW); end
            nextCycle();
        end
        applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL stall_deliver_ifW got %h expected 0", bus.ifW); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemREN !== 1'b0) begin failCount++; $display("[TB] FAIL hold_imemREN got %h expected 0", bus.imemREN); end
        testCount++; if (bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL hold_ifW got %h expected 0", bus.ifW); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.ifW !== 1'b1 || bus.ifRST !== 1'b0) begin failCount++; $display("[TB] FAIL release_write got ifW=%h ifRST=%h expected 1/0", bus.ifW, bus.ifRST); end
        testCount++; if (bus.ifinstr !== 32'hA5) begin failCount++; $display("[TB] FAIL release_instr got %h expected 000000a5", bus.ifinstr); end
        testCount++; if (bus.ifJALjump_addr !== 32'h10) begin failCount++; $display("[TB] FAIL release_npc got %h expected 00000010", bus.ifJALjump_addr); end
        testCount++; if (bus.imemREN !== 1'b0) begin failCount++; $display("[TB] FAIL release_imemREN got %h expected 0", bus.imemREN); end
        nextCycle();
        #1;
        testCount++; if (bus.imemaddr !== 32'h10 || bus.imemREN !== 1'b1) begin failCount++; $display("[TB] FAIL after_hold_addr got %h/%h expected 00000010/1", bus.imemaddr, bus.imemREN); end
    endtask

    task automatic test_redirect_hit();
        applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b1, 32'h100);
        #1;
        testCount++; if (bus.ifW !== 1'b1 || bus.ifRST !== 1'b1) begin failCount++; $display("[TB] FAIL redir_hit_flush got ifW=%h ifRST=%h expected 1/1", bus.ifW, bus.ifRST); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemaddr !== 32'h100) begin failCount++; $display("[TB] FAIL redir_hit_addr got %h expected 00000100", bus.imemaddr); end
    endtask

    task automatic test_redirect_pending();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        #1;
        testCount++; if (bus.ifW !== 1'b1 || bus.ifRST !== 1'b1) begin failCount++; $display("[TB] FAIL redir_pend_flush got ifW=%h ifRST=%h expected 1/1", bus.ifW, bus.ifRST); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        #1;
        testCount++; if (bus.imemaddr !== 32'h100) begin failCount++; $display("[TB] FAIL redir_pend_stable1 got %h expected 00000100", bus.imemaddr); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemaddr !== 32'h100 || bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL redir_pend_stable2 got %h/%h expected 00000100/0", bus.imemaddr, bus.ifW); end
        nextCycle();
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL redir_pend_discard got ifW=%h expected 0", bus.ifW); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemaddr !== 32'h300) begin failCount++; $display("[TB] FAIL redir_pend_addr got %h expected 00000300", bus.imemaddr); end
    endtask

    task automatic test_halt();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.ifW !== 1'b1 || bus.ifinstr !== 32'hFFFF_FFFF) begin failCount++; $display("[TB] FAIL halt_write got %h/%h expected 1/ffffffff", bus.ifW, bus.ifinstr); end
        testCount++; if (bus.ifJALjump_addr !== 32'h304 || bus.halted !== 1'b0) begin failCount++; $display("[TB] FAIL halt_npc got %h/%h expected 00000304/0", bus.ifJALjump_addr, bus.halted); end
        nextCycle();
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.halted !== 1'b1 || bus.imemREN !== 1'b0 || bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL halted_state got halted=%h imemREN=%h ifW=%h expected 1/0/0", bus.halted, bus.imemREN, bus.ifW); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        #1;
        testCount++; if (bus.ifW !== 1'b1 || bus.ifRST !== 1'b1) begin failCount++; $display("[TB] FAIL halt_redir_flush got ifW=%h ifRST=%h expected 1/1", bus.ifW, bus.ifRST); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.halted !== 1'b0 || bus.imemaddr !== 32'h40 || bus.imemREN !== 1'b1) begin failCount++; $display("[TB] FAIL halt_exit got halted=%h addr=%h ren=%h expected 0/00000040/1", bus.halted, bus.imemaddr, bus.imemREN); end
    endtask

    task automatic test_wrap_and_reset();
        applyStimulus(1'b1, 32'h9, 1'b0, 1'b1, 32'hFFFF_FFFC);
        nextCycle();
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemaddr !== 32'hFFFF_FFFC) begin failCount++; $display("[TB] FAIL wrap_addr got %h expected fffffffc", bus.imemaddr); end
        testCount++; if (bus.ifW !== 1'b1 || bus.ifJALjump_addr !== 32'h0) begin failCount++; $display("[TB] FAIL wrap_npc got %h/%h expected 1/00000000", bus.ifW, bus.ifJALjump_addr); end
        nextCycle();
        applyStimulus(1'b1, 32'h78, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemaddr !== 32'h0 || bus.ifJALjump_addr !== 32'h4) begin failCount++; $display("[TB] FAIL wrap_next got %h/%h expected 00000000/00000004", bus.imemaddr, bus.ifJALjump_addr); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.imemaddr !== 32'h4) begin failCount++; $display("[TB] FAIL midreq_addr got %h expected 00000004", bus.imemaddr); end
        RST = 1'b1;
        #1;
        testCount++; if (bus.imemREN !== 1'b0 || bus.imemaddr !== 32'h0 || bus.ifW !== 1'b0 || bus.ifRST !== 1'b0 || bus.halted !== 1'b0) begin failCount++; $display("[TB] FAIL midreq_reset got ren=%h addr=%h ifW=%h ifRST=%h halted=%h expected all 0", bus.imemREN, bus.imemaddr, bus.ifW, bus.ifRST, bus.halted); end
        nextCycle();
        RST = 1'b0;
        #1;
        testCount++; if (bus.imemaddr !== 32'h0 || bus.imemREN !== 1'b1) begin failCount++; $display("[TB] FAIL post_reset_addr got %h/%h expected 00000000/1", bus.imemaddr, bus.imemREN); end
    endtask

    task automatic test_halt_buffered();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL hbuf_deliver got ifW=%h expected 0", bus.ifW); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.halted !== 1'b0 || bus.imemREN !== 1'b0) begin failCount++; $display("[TB] FAIL hbuf_hold got halted=%h ren=%h expected 0/0", bus.halted, bus.imemREN); end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        testCount++; if (bus.ifW !== 1'b1 || bus.ifinstr !== 32'hFFFF_FFFF || bus.ifJALjump_addr !== 32'h4) begin failCount++; $display("[TB] FAIL hbuf_release got %h/%h/%h expected 1/ffffffff/00000004", bus.ifW, bus.ifinstr, bus.ifJALjump_addr); end
        nextCycle();
        #1;
        testCount++; if (bus.halted !== 1'b1 || bus.ifW !== 1'b0) begin failCount++; $display("[TB] FAIL hbuf_halted got halted=%h ifW=%h expected 1/0", bus.halted, bus.ifW); end
    endtask

    // Scenario sequence; each task leaves the fetch unit where the next expects it.
    initial begin
        testCount = 0;
        failCount = 0;
        RST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_stream();
        test_stall_hold();
        nextCycle();
        test_redirect_hit();
        nextCycle();
        test_redirect_pending();
        nextCycle();
        test_halt();
        nextCycle();
        test_wrap_and_reset();
        nextCycle();
        test_halt_buffered();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
